ahb_qos_arbiter: RTL and testbench

Four-master AHB bus arbiter with software-programmable per-master priority, starvation aging, burst-aware handover and locked-transfer hold. Drives Hgrant and Hmaster for the address-phase mux and Hmaster_data for the write-data/response mux. Sits between master request lines and the shared AHB master-to-slave multiplexer, and replaces plain round-robin arbitration where QoS is required.

---
 rtl/ahb_qos_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_ahb_qos_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_qos_arbiter.sv
//-----------------------------------------------------------------------------
// ahb_qos_arbiter
//
// Four-master AHB bus arbiter with software-programmable per-master priority,
// optional starvation aging, burst-aware handover and locked-transfer hold.
// Hgrant/Hmaster steer the address-phase mux, Hmaster_data steers the
// write-data/response mux one Hready edge later.
//
// Optional feature macro: AHB_ARB_AGING_EN
//   defined   : per-master age counters, STARVE_LIMIT boost and starve_flag
//   undefined : effective priority is the priority register, starve_flag = 0
//
// Ports:
//   Hclk          in   1  bus clock
//   Hresetn       in   1  asynchronous active-low reset
//   Hreq          in   4  bus request, one bit per master
//   Hlock         in   4  locked-transfer request, one bit per master
//   Hready        in   1  global transfer-done
//   Htrans        in   2  address-phase transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   Hburst        in   3  address-phase burst type
//   cfg_we        in   1  priority write strobe
//   cfg_idx       in   2  master index written
//   cfg_prio      in   2  new priority (3 = highest)
//   Hgrant        out  4  one-hot grant, registered
//   Hmaster       out  2  address-phase owner, registered
//   Hmaster_data  out  2  data-phase owner, registered
//   Hmastlock     out  1  current address phase is locked
//   starve_flag   out  4  master age >= STARVE_LIMIT
//-----------------------------------------------------------------------------
module ahb_qos_arbiter #(
   parameter int AGE_W          = 4,
   parameter int STARVE_LIMIT   = 12,
   parameter int MAX_INCR_BEATS = 16
) (
   input  logic       Hclk,
   input  logic       Hresetn,
   input  logic [3:0] Hreq,
   input  logic [3:0] Hlock,
   input  logic       Hready,
   input  logic [1:0] Htrans,
   input  logic [2:0] Hburst,
   input  logic       cfg_we,
   input  logic [1:0] cfg_idx,
   input  logic [1:0] cfg_prio,
   output logic [3:0] Hgrant,
   output logic [1:0] Hmaster,
   output logic [1:0] Hmaster_data,
   output logic       Hmastlock,
   output logic [3:0] starve_flag
);

   // The beat counter must hold both the longest fixed burst (15) and the
   // INCR saturation value.
   localparam int                CNT_TOP = (MAX_INCR_BEATS > 15) ? MAX_INCR_BEATS : 15;
   localparam int                CNT_W   = $clog2(CNT_TOP + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_INCR_BEATS);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [2:0] BU_SINGLE = 3'b000;
   localparam logic [2:0] BU_INCR   = 3'b001;

   typedef enum logic [1:0] {
      ST_ARB    = 2'd0,
      ST_FIXED  = 2'd1,
      ST_INCR   = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_grant;
   logic [1:0]       r_master;
   logic [1:0]       r_master_data;
   logic             r_mastlock;
   logic [1:0]       r_prio [4];
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       w_eff_prio [4];
   logic [1:0]       w_winner;
   logic             w_ho_allow;
   logic             w_lock_nxt;

   // Beats are Hready edges carrying NONSEQ/SEQ; BUSY and wait states are not.
   logic w_beat;
   logic w_nonseq;
   logic w_idle;
   logic w_own_req;
   logic w_own_lock;
   logic w_other_req;

   assign w_beat      = Hready && Htrans[1];
   assign w_nonseq    = Hready && (Htrans == TR_NONSEQ);
   assign w_idle      = (Htrans == TR_IDLE);
   assign w_own_req   = Hreq[r_master];
   assign w_own_lock  = Hlock[r_master];
   assign w_other_req = |(Hreq & ~r_grant);

   // Beats remaining after the NONSEQ of a fixed-length burst.
   function automatic logic [CNT_W-1:0] burst_remaining(input logic [2:0] burst);
      case (burst)
         3'b010, 3'b011: return CNT_W'(3);
         3'b100, 3'b101: return CNT_W'(7);
         3'b110, 3'b111: return CNT_W'(15);
         default:        return '0;
      endcase
   endfunction

   //--------------------------------------------------------------------------
   // Priority registers. A write lands on the edge, so an arbitration decision
   // taken on that same edge still sees the old value.
   //--------------------------------------------------------------------------
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         // NOTE: this is a four-entry register file, not a RAM; resetting it
         // is cheap and gives software a known all-zero starting priority.
         for (int i = 0; i < 4; i++) r_prio[i] <= '0;
      end else if (cfg_we) begin
         r_prio[cfg_idx] <= cfg_prio;
      end
   end

   //--------------------------------------------------------------------------
   // Aging and effective priority
   //--------------------------------------------------------------------------
`ifdef AHB_ARB_AGING_EN
   localparam logic [AGE_W-1:0] AGE_SAT = '1;

   logic [AGE_W-1:0] r_age     [4];
   logic [AGE_W-1:0] w_age_nxt [4];
   logic [3:0]       r_starve;

   always_comb begin : p_age_nxt
      for (int i = 0; i < 4; i++) begin
         w_age_nxt[i] = r_age[i];
         if (!Hreq[i] || (w_ho_allow && (w_winner == 2'(i))))
            w_age_nxt[i] = '0;
         else if (Hready && (r_master != 2'(i)) && (r_age[i] != AGE_SAT))
            w_age_nxt[i] = r_age[i] + 1'b1;
      end
   end

   // starve_flag is taken from the next age so it is always equal to
   // (r_age >= STARVE_LIMIT) and can be reused for the boost.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         for (int i = 0; i < 4; i++) r_age[i] <= '0;
         r_starve <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            r_age[i]    <= w_age_nxt[i];
            r_starve[i] <= (int'(w_age_nxt[i]) >= STARVE_LIMIT);
         end
      end
   end

   always_comb begin : p_eff_prio
      for (int i = 0; i < 4; i++)
         w_eff_prio[i] = r_starve[i] ? 3'd4 : {1'b0, r_prio[i]};
   end

   assign starve_flag = r_starve;
`else
   always_comb begin : p_eff_prio
      for (int i = 0; i < 4; i++)
         w_eff_prio[i] = {1'b0, r_prio[i]};
   end

   assign starve_flag = '0;

   // AGE_W and STARVE_LIMIT have no effect in this build; the empty branch
   // keeps them referenced so both builds share one parameter list.
   if ((AGE_W < 1) || (STARVE_LIMIT < 0)) begin : g_age_params_unused
   end
`endif

   //--------------------------------------------------------------------------
   // Winner: highest effective priority, ties resolved by scanning from
   // Hmaster+1 with wrap so the current owner comes last. Parks on Hmaster
   // when nobody requests.
   //--------------------------------------------------------------------------
   always_comb begin : p_winner
      logic [2:0] v_best;
      logic       v_found;
      logic [1:0] v_idx;
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned and no latch is inferred.
      w_winner = r_master;
      v_best   = '0;
      v_found  = 1'b0;
      v_idx    = '0;
      for (int k = 1; k <= 4; k++) begin
         v_idx = r_master + 2'(k);
         if (Hreq[v_idx] && (!v_found || (w_eff_prio[v_idx] > v_best))) begin
            v_found  = 1'b1;
            v_best   = w_eff_prio[v_idx];
            w_winner = v_idx;
         end
      end
   end

   //--------------------------------------------------------------------------
   // Beat counter datapath: FIXED counts down remaining beats, INCR counts up
   // to the forced-handover limit.
   //--------------------------------------------------------------------------
   always_comb begin : p_cnt_nxt
      w_cnt_nxt = r_cnt;
      case (r_state)
         ST_ARB:
            if (w_nonseq)
               w_cnt_nxt = (Hburst == BU_INCR) ? CNT_W'(1) : burst_remaining(Hburst);
         ST_FIXED:
            if (w_beat && (r_cnt != '0)) w_cnt_nxt = r_cnt - 1'b1;
         ST_INCR:
            if (w_beat && (r_cnt != CNT_MAX)) w_cnt_nxt = r_cnt + 1'b1;
         default: ;
      endcase
   end

   //--------------------------------------------------------------------------
   // FSM: state register
   //--------------------------------------------------------------------------
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_state <= ST_ARB;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples pre-edge values regardless of process order.
         r_state <= w_state_nxt;
      end
   end

   //--------------------------------------------------------------------------
   // FSM: next state. Burst/lock tracking is decided on the edge of the beat,
   // using the post-beat counter value, so the last beat's edge is also the
   // handover edge.
   //--------------------------------------------------------------------------
   always_comb begin : p_state_nxt
      w_state_nxt = r_state;
      case (r_state)
         ST_ARB: begin
            if (w_beat && w_own_lock)
               w_state_nxt = ST_LOCKED;
            else if (w_nonseq && (Hburst == BU_INCR))
               w_state_nxt = ST_INCR;
            else if (w_nonseq && (Hburst != BU_SINGLE))
               w_state_nxt = ST_FIXED;
         end
         ST_FIXED:
            if (Hready && (w_idle || (w_cnt_nxt == '0)))
               w_state_nxt = ST_ARB;
         ST_INCR:
            if (Hready && (!w_own_req || w_idle ||
                           ((w_cnt_nxt == CNT_MAX) && w_other_req)))
               w_state_nxt = ST_ARB;
         ST_LOCKED:
            // Leaving on this edge still blocks handover, so the owner keeps
            // one more unlocked transfer before the grant can move.
            if (Hready && !w_own_lock)
               w_state_nxt = ST_ARB;
         default:
            w_state_nxt = ST_ARB;
      endcase
   end

   //--------------------------------------------------------------------------
   // FSM: outputs
   //--------------------------------------------------------------------------
   always_comb begin : p_fsm_out
      w_ho_allow = Hready && (r_state != ST_LOCKED) && (w_state_nxt == ST_ARB);
      w_lock_nxt = (w_state_nxt == ST_LOCKED);
   end

   //--------------------------------------------------------------------------
   // Grant, owner and data-phase owner registers
   //--------------------------------------------------------------------------
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_grant       <= 4'b0001;
         r_master      <= '0;
         r_master_data <= '0;
         r_mastlock    <= 1'b0;
         r_cnt         <= '0;
      end else begin
         if (w_ho_allow) begin
            r_grant  <= 4'b0001 << w_winner;
            r_master <= w_winner;
         end
         if (Hready) r_master_data <= r_master;
         r_mastlock <= w_lock_nxt;
         r_cnt      <= w_cnt_nxt;
      end
   end

   assign Hgrant       = r_grant;
   assign Hmaster      = r_master;
   assign Hmaster_data = r_master_data;
   assign Hmastlock    = r_mastlock;

endmodule

// File: tb/tb_ahb_qos_arbiter.sv
//-----------------------------------------------------------------------------
// tb_ahb_qos_arbiter
//
// Directed self-checking bench for ahb_qos_arbiter. Inputs are driven 1 ns
// after each rising edge and outputs are sampled at the same point, well away
// from the next active edge. Expected values are hand-computed constants;
// aging-dependent expectations follow AHB_ARB_AGING_EN.
//-----------------------------------------------------------------------------
module tb_ahb_qos_arbiter;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

`ifdef AHB_ARB_AGING_EN
   localparam bit AGING = 1'b1;
`else
   localparam bit AGING = 1'b0;
`endif

   logic       Hclk;
   logic       Hresetn;
   logic [3:0] Hreq;
   logic [3:0] Hlock;
   logic       Hready;
   logic [1:0] Htrans;
   logic [2:0] Hburst;
   logic       cfg_we;
   logic [1:0] cfg_idx;
   logic [1:0] cfg_prio;
   logic [3:0] Hgrant;
   logic [1:0] Hmaster;
   logic [1:0] Hmaster_data;
   logic       Hmastlock;
   logic [3:0] starve_flag;

   int n_total = 0;
   int n_bad   = 0;

   ahb_qos_arbiter dut (
      .Hclk         (Hclk),
      .Hresetn      (Hresetn),
      .Hreq         (Hreq),
      .Hlock        (Hlock),
      .Hready       (Hready),
      .Htrans       (Htrans),
      .Hburst       (Hburst),
      .cfg_we       (cfg_we),
      .cfg_idx      (cfg_idx),
      .cfg_prio     (cfg_prio),
      .Hgrant       (Hgrant),
      .Hmaster      (Hmaster),
      .Hmaster_data (Hmaster_data),
      .Hmastlock    (Hmastlock),
      .starve_flag  (starve_flag)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] idx, input logic [1:0] prio);
      cfg_we   = 1'b1;
      cfg_idx  = idx;
      cfg_prio = prio;
      tick();
      cfg_we   = 1'b0;
   endtask

   initial begin
      Hresetn  = 1'b0;
      Hreq     = '0;
      Hlock    = '0;
      Hready   = 1'b1;
      Htrans   = T_IDLE;
      Hburst   = 3'b000;
      cfg_we   = 1'b0;
      cfg_idx  = '0;
      cfg_prio = '0;

      // Reset values
      #12;
      check("rst_grant",   32'(Hgrant),       32'h1);
      check("rst_master",  32'(Hmaster),      32'h0);
      check("rst_mdata",   32'(Hmaster_data), 32'h0);
      check("rst_lock",    32'(Hmastlock),    32'h0);
      check("rst_starve",  32'(starve_flag),  32'h0);
      Hresetn = 1'b1;

      // Parking with no requests
      repeat (3) tick();
      check("park_grant",  32'(Hgrant),       32'h1);
      check("park_master", 32'(Hmaster),      32'h0);
      check("park_mdata",  32'(Hmaster_data), 32'h0);

      // Priorities {0,0,3,1}: m2 wins and keeps the bus with SINGLE transfers
      cfg(2'd0, 2'd0);
      cfg(2'd1, 2'd0);
      cfg(2'd2, 2'd3);
      cfg(2'd3, 2'd1);
      Hreq = 4'b1111;
      tick();
      check("prio_grant",  32'(Hgrant),       32'h4);
      check("prio_master", 32'(Hmaster),      32'h2);
      check("prio_mdata",  32'(Hmaster_data), 32'h0);
      Htrans = T_NONSEQ;
      Hburst = 3'b000;
      repeat (3) tick();
      check("prio_hold",   32'(Hgrant),       32'h4);
      check("prio_hmdata", 32'(Hmaster_data), 32'h2);

      // cfg write on a handover edge: old priority applies on that edge
      cfg(2'd3, 2'd3);
      check("cfgsim_old",  32'(Hmaster),      32'h2);
      tick();
      check("cfgsim_new",  32'(Hgrant),       32'h8);

      Hreq   = '0;
      Htrans = T_IDLE;
      cfg(2'd2, 2'd0);
      cfg(2'd3, 2'd0);

      // Equal priorities: round-robin rotation 0->1->2->3->0
      Hreq = 4'b0001;
      tick();
      check("rr_start",    32'(Hmaster),      32'h0);
      Hreq   = 4'b1111;
      Htrans = T_NONSEQ;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("rr_grant", 32'(Hgrant),       32'(4'b0001 << (i % 4)));
         check("rr_mdata", 32'(Hmaster_data), 32'(i - 1));
      end

      // m1 INCR8 with two wait states; m3 has higher priority
      Hreq   = '0;
      Htrans = T_IDLE;
      cfg(2'd3, 2'd2);
      Hreq = 4'b0010;
      tick();
      check("b8_own",      32'(Hmaster),      32'h1);
      Hreq   = 4'b1010;
      Htrans = T_NONSEQ;
      Hburst = 3'b101;
      tick();                       // beat 1
      check("b8_beat1",    32'(Hmaster),      32'h1);
      Htrans = T_SEQ;
      tick();                       // beat 2
      tick();                       // beat 3
      Hready = 1'b0;
      tick();                       // wait state
      check("b8_wait",     32'(Hgrant),       32'h2);
      Hready = 1'b1;
      tick();                       // beat 4
      tick();                       // beat 5
      Hready = 1'b0;
      tick();                       // wait state
      Hready = 1'b1;
      tick();                       // beat 6
      tick();                       // beat 7
      check("b8_beat7",    32'(Hgrant),       32'h2);
      check("b8_b7mdata",  32'(Hmaster_data), 32'h1);
      tick();                       // beat 8
      check("b8_hgrant",   32'(Hgrant),       32'h8);
      check("b8_hmaster",  32'(Hmaster),      32'h3);
      check("b8_hmdata",   32'(Hmaster_data), 32'h1);
      Htrans = T_IDLE;
      Hburst = 3'b000;
      Hreq   = '0;
      tick();

      // m0 undefined-length INCR, m2 requesting: forced handover at beat 16
      Hreq = 4'b0001;
      tick();
      check("incr_own",    32'(Hmaster),      32'h0);
      Hreq   = 4'b0101;
      Htrans = T_NONSEQ;
      Hburst = 3'b001;
      tick();                       // beat 1
      Htrans = T_SEQ;
      repeat (14) tick();           // beats 2..15
      check("incr_b15",    32'(Hmaster),      32'h0);
      tick();                       // beat 16
      check("incr_force",  32'(Hmaster),      32'h2);
      check("incr_fgrant", 32'(Hgrant),       32'h4);

      // Locked transfer by m2 with m0 waiting
      Htrans = T_NONSEQ;
      Hburst = 3'b000;
      Hlock  = 4'b0100;
      tick();
      check("lock_enter",  32'(Hmastlock),    32'h1);
      check("lock_own",    32'(Hmaster),      32'h2);
      tick();
      check("lock_hold",   32'(Hmaster),      32'h2);
      Hlock = 4'b0000;
      tick();
      check("lock_exit",   32'(Hmaster),      32'h2);
      check("lock_exitml", 32'(Hmastlock),    32'h0);
      tick();
      check("lock_after",  32'(Hmaster),      32'h0);

      // Reset asserted mid-lock
      Hreq   = 4'b0010;
      Htrans = T_IDLE;
      tick();
      check("mrst_own",    32'(Hmaster),      32'h1);
      Hlock  = 4'b0010;
      Htrans = T_NONSEQ;
      tick();
      check("mrst_locked", 32'(Hmastlock),    32'h1);
      #2;
      Hresetn = 1'b0;
      #1;
      check("mrst_grant",  32'(Hgrant),       32'h1);
      check("mrst_master", 32'(Hmaster),      32'h0);
      check("mrst_lock",   32'(Hmastlock),    32'h0);
      Hlock   = '0;
      Hreq    = '0;
      Htrans  = T_IDLE;
      #2;
      Hresetn = 1'b1;
      Hreq = 4'b1100;               // m3 prio was 2; reset clears it to 0
      tick();
      check("mrst_prio",   32'(Hmaster),      32'h2);
      Hreq = 4'b1000;
      tick();
      check("mrst_arb",    32'(Hmaster),      32'h3);

      // Aging: priorities {3,0,0,0}, m0 continuous, m1 waiting
      cfg(2'd0, 2'd3);
      Hreq = 4'b0001;
      tick();
      check("age_own",     32'(Hmaster),      32'h0);
      Hreq   = 4'b0011;
      Htrans = T_NONSEQ;
      repeat (11) tick();
      check("age_e11",     32'(starve_flag),  32'h0);
      tick();
      check("age_e12",     32'(starve_flag),  AGING ? 32'h2 : 32'h0);
      check("age_e12own",  32'(Hmaster),      32'h0);
      tick();
      check("age_e13own",  32'(Hmaster),      AGING ? 32'h1 : 32'h0);
      check("age_e13flag", 32'(starve_flag),  32'h0);
      tick();
      check("age_e14own",  32'(Hmaster),      32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
